// File: rtl/noc_local_injector_pkg.sv
// Shared NoC definitions: direction codes, flit width and header layout,
// plus the injector state encoding and a header-building helper.
package noc_pkg;
    localparam int FLIT_W = 8;

    localparam logic [2:0] DIR_L    = 3'd0;
    localparam logic [2:0] DIR_N    = 3'd1;
    localparam logic [2:0] DIR_E    = 3'd2;
    localparam logic [2:0] DIR_S    = 3'd3;
    localparam logic [2:0] DIR_W    = 3'd4;
    localparam logic [2:0] DIR_IDLE = 3'd7;

    localparam int HDR_DY_LSB  = 0;
    localparam int HDR_DX_LSB  = 2;
    localparam int HDR_LEN_LSB = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEAD,
        ST_BODY
    } inj_state_t;

    function automatic logic [FLIT_W-1:0] make_header(input logic [3:0] len,
                                                      input logic [1:0] dest_x,
                                                      input logic [1:0] dest_y);
        logic [FLIT_W-1:0] h;
        h = '0;
        h[HDR_LEN_LSB +: 4] = len;
        h[HDR_DX_LSB +: 2]  = dest_x;
        h[HDR_DY_LSB +: 2]  = dest_y;
        return h;
    endfunction
endpackage

// File: rtl/noc_local_injector_if.sv
// Core-side command/payload channel plus the router local-port request/grant
// channel. master = core and router side, slave = the injector.
interface noc_local_injector_if;
    import noc_pkg::*;

    logic              pkt_valid;
    logic              pkt_ready;
    logic [1:0]        pkt_dest_x;
    logic [1:0]        pkt_dest_y;
    logic [3:0]        pkt_len;
    logic              data_valid;
    logic              data_ready;
    logic [FLIT_W-1:0] data_in;
    logic [FLIT_W-1:0] flit_out;
    logic [2:0]        request_out;
    logic              grant_in;

    modport master (
        output pkt_valid, pkt_dest_x, pkt_dest_y, pkt_len,
        output data_valid, data_in, grant_in,
        input  pkt_ready, data_ready, flit_out, request_out
    );

    modport slave (
        input  pkt_valid, pkt_dest_x, pkt_dest_y, pkt_len,
        input  data_valid, data_in, grant_in,
        output pkt_ready, data_ready, flit_out, request_out
    );
endinterface

// File: rtl/noc_local_injector_route_xy.sv
// Dimension-ordered (X then Y) first-hop direction for a destination,
// seen from node (MY_X, MY_Y). Shared with the router.
module noc_route_xy
    import noc_pkg::*;
#(
    parameter int MY_X = 1,
    parameter int MY_Y = 1
) (
    input  logic [1:0] dest_x,
    input  logic [1:0] dest_y,
    output logic [2:0] dir
);
    localparam logic [1:0] MX = MY_X[1:0];
    localparam logic [1:0] MYY = MY_Y[1:0];

    always_comb begin
        dir = DIR_L;
        if (dest_x > MX)
            dir = DIR_E;
        else if (dest_x < MX)
            dir = DIR_W;
        else if (dest_y > MYY)
            dir = DIR_S;
        else if (dest_y < MYY)
            dir = DIR_N;
    end
endmodule

// File: rtl/noc_local_injector.sv
// Local-port packetizer: turns a core packet command plus payload bytes into a
// header flit and LEN body flits toward the router. Optional NOC_INJ_STATS_EN
// adds saturating sent-packet and stall counters.
module noc_local_injector
    import noc_pkg::*;
#(
    parameter int MY_X = 1,
    parameter int MY_Y = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    noc_local_injector_if.slave   bus
`ifdef NOC_INJ_STATS_EN
    ,
    output logic [15:0]           pkt_sent_cnt,
    output logic [15:0]           stall_cnt
`endif
);
    inj_state_t        state;
    logic              hold_v;
    logic [FLIT_W-1:0] hold_d;
    logic [2:0]        dir;
    logic [3:0]        len_q;
    logic [3:0]        remaining;
    logic              pkt_ready_q;
    logic [2:0]        route_dir;
    logic              granted;
    logic              byte_acc;

    noc_route_xy #(.MY_X(MY_X), .MY_Y(MY_Y)) u_route (
        .dest_x (bus.pkt_dest_x),
        .dest_y (bus.pkt_dest_y),
        .dir    (route_dir)
    );

    assign bus.flit_out    = hold_d;
    assign bus.request_out = hold_v ? dir : DIR_IDLE;
    assign bus.pkt_ready   = pkt_ready_q;

    // A granted slot may be refilled in the same cycle, hence grant feeds ready.
    assign bus.data_ready = (state == ST_BODY) && (remaining != 4'd0) &&
                            (!hold_v || bus.grant_in);
    assign granted  = hold_v && bus.grant_in;
    assign byte_acc = bus.data_ready && bus.data_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            hold_v      <= 1'b0;
            hold_d      <= '0;
            dir         <= DIR_IDLE;
            len_q       <= 4'd0;
            remaining   <= 4'd0;
            pkt_ready_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pkt_ready_q && bus.pkt_valid) begin
                        hold_d      <= make_header(bus.pkt_len, bus.pkt_dest_x, bus.pkt_dest_y);
                        hold_v      <= 1'b1;
                        dir         <= route_dir;
                        len_q       <= bus.pkt_len;
                        pkt_ready_q <= 1'b0;
                        state       <= ST_HEAD;
                    end else begin
                        pkt_ready_q <= 1'b1;
                    end
                end
                ST_HEAD: begin
                    if (granted) begin
                        hold_v <= 1'b0;
                        if (len_q == 4'd0) begin
                            pkt_ready_q <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            remaining <= len_q;
                            state     <= ST_BODY;
                        end
                    end
                end
                ST_BODY: begin
                    if (byte_acc) begin
                        hold_d    <= bus.data_in;
                        hold_v    <= 1'b1;
                        remaining <= remaining - 4'd1;
                    end else if (granted) begin
                        hold_v <= 1'b0;
                    end
                    // Body complete once nothing is left to accept and the slot drains.
                    if (remaining == 4'd0 && (!hold_v || granted)) begin
                        pkt_ready_q <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef NOC_INJ_STATS_EN
    logic last_granted;

    assign last_granted = granted &&
                          ((state == ST_HEAD && len_q == 4'd0) ||
                           (state == ST_BODY && remaining == 4'd0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_sent_cnt <= 16'd0;
            stall_cnt    <= 16'd0;
        end else begin
            if (last_granted && pkt_sent_cnt != 16'hFFFF)
                pkt_sent_cnt <= pkt_sent_cnt + 16'd1;
            if (hold_v && !bus.grant_in && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_noc_local_injector.sv
// Bench for noc_local_injector at node (1,1): directed scenarios with literal
// expectations, then random traffic checked every cycle against a packet-level model.
module tb_noc_local_injector;
    import noc_pkg::*;

    localparam int MY_X = 1;
    localparam int MY_Y = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    noc_local_injector_if bus();

`ifdef NOC_INJ_STATS_EN
    logic [15:0] pkt_sent_cnt;
    logic [15:0] stall_cnt;
`endif

    noc_local_injector #(.MY_X(MY_X), .MY_Y(MY_Y)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef NOC_INJ_STATS_EN
        ,
        .pkt_sent_cnt (pkt_sent_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] byte_q[$];
    logic [7:0] exp_flits[$];
    logic [7:0] rx_log[$];
    logic [7:0] body_buf[16];
    logic [7:0] lit[8];

    int grant_mode = 1;
    int data_gap   = 0;

    // Packet-level model state
    bit         m_active, m_hdr_done, m_held, m_pr;
    logic [7:0] m_flit;
    int         m_dir, m_len, m_left, m_sent, m_stall;

    logic       c_g, c_pv, c_dv, c_gr, c_acc, c_edr;
    logic [7:0] c_din;
    int         c_dx, c_dy, c_len, c_ereq;

    logic       f_acc;
    int         f_gap = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int route_model(input int dx, input int dy);
        int ddx = dx - MY_X;
        int ddy = dy - MY_Y;
        if (ddx > 0) return 2;
        if (ddx < 0) return 4;
        if (ddy > 0) return 3;
        if (ddy < 0) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_active = 0; m_hdr_done = 0; m_held = 0; m_pr = 0;
        m_flit = 8'h00; m_dir = 7; m_len = 0; m_left = 0;
        m_sent = 0; m_stall = 0;
    endtask

    // Compare process: outputs against the model every cycle, then advance the model.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("rst_request", bus.request_out, 7);
                check("rst_flit", bus.flit_out, 0);
                check("rst_pkt_ready", bus.pkt_ready, 0);
                check("rst_data_ready", bus.data_ready, 0);
`ifdef NOC_INJ_STATS_EN
                check("rst_pkt_sent_cnt", pkt_sent_cnt, 0);
                check("rst_stall_cnt", stall_cnt, 0);
`endif
                model_reset();
                exp_flits.delete();
            end else begin
                c_g   = bus.grant_in;
                c_pv  = bus.pkt_valid;
                c_dv  = bus.data_valid;
                c_din = bus.data_in;
                c_dx  = int'(bus.pkt_dest_x);
                c_dy  = int'(bus.pkt_dest_y);
                c_len = int'(bus.pkt_len);
                c_ereq = m_held ? m_dir : 7;
                c_edr  = m_active && m_hdr_done && (m_left != 0) && (!m_held || c_g);
                check("request", bus.request_out, c_ereq);
                check("flit_out", bus.flit_out, m_flit);
                check("pkt_ready", bus.pkt_ready, m_pr);
                check("data_ready", bus.data_ready, c_edr);
`ifdef NOC_INJ_STATS_EN
                check("pkt_sent_cnt", pkt_sent_cnt, m_sent);
                check("stall_cnt", stall_cnt, m_stall);
`endif
                if (bus.request_out != 3'd7 && c_g) begin
                    if (exp_flits.size() == 0)
                        check("unexpected_flit", bus.flit_out, 8'hxx === 8'hxx ? 9'h100 : 9'h100);
                    else
                        check("flit_order", bus.flit_out, exp_flits.pop_front());
                    rx_log.push_back(bus.flit_out);
                end

                c_gr = m_held && c_g;
                if (m_held && !c_g && m_stall < 65535) m_stall++;
                if (c_gr && ((!m_hdr_done && m_len == 0) || (m_hdr_done && m_left == 0)) && m_sent < 65535)
                    m_sent++;

                if (!m_active) begin
                    if (m_pr && c_pv) begin
                        m_active = 1; m_hdr_done = 0; m_held = 1;
                        m_flit = 8'(c_len * 16 + c_dx * 4 + c_dy);
                        m_dir = route_model(c_dx, c_dy);
                        m_len = c_len; m_left = c_len; m_pr = 0;
                    end else begin
                        m_pr = 1;
                    end
                end else if (!m_hdr_done) begin
                    if (c_gr) begin
                        m_held = 0; m_hdr_done = 1;
                        if (m_len == 0) begin m_active = 0; m_pr = 1; end
                    end
                end else begin
                    c_acc = c_edr && c_dv;
                    if (m_left == 0 && (!m_held || c_gr)) begin
                        m_held = 0; m_active = 0; m_pr = 1;
                    end else if (c_acc) begin
                        m_flit = c_din; m_held = 1; m_left--;
                    end else if (c_gr) begin
                        m_held = 0;
                    end
                end
            end
        end
    end

    // Feeder: grant pattern and payload bytes from byte_q, updated 1 ns after each edge.
    initial begin
        bus.data_valid = 1'b0;
        bus.data_in    = 8'h00;
        bus.grant_in   = 1'b0;
        forever begin
            @(negedge clk);
            f_acc = bus.data_valid && bus.data_ready && rst;
            @(posedge clk);
            #1;
            if (f_acc && byte_q.size() > 0) begin
                void'(byte_q.pop_front());
                f_gap = (data_gap < 0) ? int'($urandom_range(0, 2)) : data_gap;
            end
            case (grant_mode)
                0:       bus.grant_in = 1'b1;
                1:       bus.grant_in = 1'b0;
                default: bus.grant_in = 1'($urandom_range(0, 1));
            endcase
            if (f_gap > 0) begin
                bus.data_valid = 1'b0;
                f_gap--;
            end else if (byte_q.size() > 0) begin
                bus.data_valid = (data_gap >= 0) || ($urandom_range(0, 3) != 0);
                bus.data_in    = byte_q[0];
            end else begin
                bus.data_valid = 1'b0;
            end
        end
    end

    task automatic send_pkt(input logic [1:0] dx, input logic [1:0] dy, input logic [3:0] len);
        bit ok = 0;
        exp_flits.push_back({len, dx, dy});
        for (int i = 0; i < int'(len); i++) begin
            exp_flits.push_back(body_buf[i]);
            byte_q.push_back(body_buf[i]);
        end
        bus.pkt_dest_x = dx;
        bus.pkt_dest_y = dy;
        bus.pkt_len    = len;
        bus.pkt_valid  = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.pkt_ready) begin ok = 1; break; end
        end
        @(posedge clk);
        #2;
        bus.pkt_valid = 1'b0;
        check("pkt_accept", ok, 1);
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.pkt_ready && bus.request_out == 3'd7 && exp_flits.size() == 0) begin ok = 1; break; end
        end
        @(posedge clk);
        #2;
        check("drain", ok, 1);
    endtask

    task automatic check_rx(input string name, input int n);
        check({name, "_count"}, rx_log.size(), n);
        for (int i = 0; i < n; i++)
            if (i < rx_log.size()) check({name, "_flit"}, rx_log[i], lit[i]);
    endtask

    initial begin
        bus.pkt_valid = 1'b0; bus.pkt_dest_x = 2'd0; bus.pkt_dest_y = 2'd0; bus.pkt_len = 4'd0;
        repeat (3) @(posedge clk);
        #2;
        check("t1_rst_request", bus.request_out, 7);
        check("t1_rst_flit", bus.flit_out, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // Loopback header-only packet
        grant_mode = 1;
        rx_log.delete();
        send_pkt(2'd1, 2'd1, 4'd0);
        check("t1_header", bus.flit_out, 8'h05);
        check("t1_request", bus.request_out, 0);
        grant_mode = 0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        check("t1_request_idle", bus.request_out, 7);
        check("t1_pkt_ready", bus.pkt_ready, 1);

        // East packet, continuous grant and data
        rx_log.delete();
        body_buf[0] = 8'hAA; body_buf[1] = 8'hBB; body_buf[2] = 8'hCC;
        send_pkt(2'd3, 2'd1, 4'd3);
        check("t2_header", bus.flit_out, 8'h3D);
        check("t2_request", bus.request_out, 2);
        wait_idle(200);
        lit[0] = 8'h3D; lit[1] = 8'hAA; lit[2] = 8'hBB; lit[3] = 8'hCC;
        check_rx("t2", 4);

        // Grant withheld for several cycles
        rx_log.delete();
        grant_mode = 1;
        body_buf[0] = 8'h11; body_buf[1] = 8'h22;
        send_pkt(2'd1, 2'd0, 4'd2);
        for (int k = 0; k < 5; k++) begin
            check("t3_flit_stable", bus.flit_out, 8'h24);
            check("t3_request", bus.request_out, 1);
            check("t3_data_ready", bus.data_ready, 0);
            @(posedge clk); #2;
        end
        grant_mode = 0;
        wait_idle(200);
        lit[0] = 8'h24; lit[1] = 8'h11; lit[2] = 8'h22;
        check_rx("t3", 3);

        // Payload bubbles toward the west
        rx_log.delete();
        data_gap = 3;
        body_buf[0] = 8'h55; body_buf[1] = 8'h66;
        send_pkt(2'd0, 2'd2, 4'd2);
        check("t4_header", bus.flit_out, 8'h22);
        check("t4_request", bus.request_out, 4);
        wait_idle(200);
        lit[0] = 8'h22; lit[1] = 8'h55; lit[2] = 8'h66;
        check_rx("t4", 3);
        data_gap = 0;

        // Reset in the middle of a packet
        rx_log.delete();
        for (int i = 0; i < 4; i++) body_buf[i] = 8'(i + 1);
        send_pkt(2'd2, 2'd1, 4'd4);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rx_log.size() >= 3) break;
        end
        @(posedge clk); #2;
        rst = 1'b0;
        byte_q.delete();
        exp_flits.delete();
        #1;
        check("t5_request_rst", bus.request_out, 7);
        check("t5_flit_rst", bus.flit_out, 0);
        check("t5_pkt_ready_rst", bus.pkt_ready, 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        rx_log.delete();
        body_buf[0] = 8'h77;
        send_pkt(2'd1, 2'd2, 4'd1);
        check("t5_header", bus.flit_out, 8'h16);
        check("t5_request", bus.request_out, 3);
        wait_idle(200);
        lit[0] = 8'h16; lit[1] = 8'h77;
        check_rx("t5", 2);

        // Random traffic, random grant and payload gaps, back-to-back commands
        grant_mode = 2;
        data_gap   = -1;
        for (int p = 0; p < 40; p++) begin
            for (int i = 0; i < 16; i++) body_buf[i] = 8'($urandom_range(0, 255));
            send_pkt(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     4'(($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 15)));
        end
        wait_idle(5000);
        check("final_scoreboard_empty", exp_flits.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got still running expected finished");
        $fatal(1, "[TB] time limit reached");
    end
endmodule
